// File: rtl/crt_feeder_if.sv
// Handshake between the character FIFO feeder and the downstream CRT screen writer.
// The feeder is the master: it offers characters, the writer reports done/clearing.
interface crt_feeder_if;
   logic       crt_insert;
   logic [7:0] crt_data;
   logic       crt_done;
   logic       crt_clearing;

   modport master (
      output crt_insert,
      output crt_data,
      input  crt_done,
      input  crt_clearing
   );

   modport slave (
      input  crt_insert,
      input  crt_data,
      output crt_done,
      output crt_clearing
   );
endinterface

// File: rtl/crt_feeder.sv
// Buffers 7-bit characters from the TTY output path and hands them one at a time
// to the CRT screen writer through an insert/done handshake.
module crt_feeder #(
   parameter int DEPTH = 16
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    wr,
   input  logic [7:0]              wr_data,
   input  logic                    clr_ovf,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   crt_feeder_if.master            crt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);

   typedef enum logic [2:0] {
      F_INIT,
      F_IDLE,
      F_INSERT,
      F_WAIT_DONE,
      F_WAIT_IDLE
   } state_t;

   state_t        state;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          low_seen;
   logic [6:0]    wr_char;
   logic          parity_unused;
   logic          accept;
   logic          pop;
   logic          push;
   logic          lost;

   assign wr_char       = wr_data[6:0];
   assign parity_unused = wr_data[7];
   // NUL and DEL never reach the screen, so they are dropped before the FIFO.
   assign accept = wr && (wr_char != 7'h00) && (wr_char != 7'h7f);
   assign pop    = (state == F_IDLE) && (count != '0) && !crt.crt_clearing;
   assign push   = accept && (!full || pop);
   assign lost   = accept && full && !pop;
   assign full   = (count == FULL_COUNT);

   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr] <= {1'b0, wr_char};
   end

   // Pointers, occupancy and the sticky overflow flag; a new loss beats clr_ovf.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)
            count <= count + CNT_ONE;
         else if (pop && !push)
            count <= count - CNT_ONE;
         if (lost)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
      end
   end

   // Handshake sequencer; the writer re-initialising aborts whatever is in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= F_INIT;
         low_seen       <= 1'b0;
         crt.crt_insert <= 1'b0;
         crt.crt_data   <= 8'h00;
      end else begin
         crt.crt_insert <= 1'b0;
         if (state != F_INIT && crt.crt_clearing) begin
            state    <= F_INIT;
            low_seen <= 1'b0;
         end else begin
            case (state)
               F_INIT: begin
                  if (crt.crt_clearing) begin
                     low_seen <= 1'b0;
                  end else if (low_seen) begin
                     low_seen <= 1'b0;
                     state    <= F_IDLE;
                  end else begin
                     low_seen <= 1'b1;
                  end
               end
               F_IDLE: begin
                  if (pop) begin
                     crt.crt_data   <= mem[rd_ptr];
                     crt.crt_insert <= 1'b1;
                     state          <= F_INSERT;
                  end
               end
               F_INSERT: begin
                  state <= F_WAIT_DONE;
               end
               F_WAIT_DONE: begin
                  if (crt.crt_done)
                     state <= F_WAIT_IDLE;
               end
               F_WAIT_IDLE: begin
                  if (!crt.crt_done)
                     state <= F_IDLE;
               end
               default: begin
                  state <= F_INIT;
               end
            endcase
         end
      end
   end

endmodule
